ws_sram_writer: RTL and testbench

- Write-S unit for the Milestone 2 decoder; the reverse of the fetch-S' (FS) unit.
- Reads one 8x8 block of IDCT results (S) from the S/S' dual-port RAM, port a, 64 signed 32-bit entries in row-major order.
- Clips each result to 8 bits, packs two pixels per 16-bit word and writes the 32 words into the Y, U or V segment of SRAM at the block position (RB, CB).
- Driven by the Milestone 2 top-level FSM through a start/done handshake.

---
 rtl/ws_sram_writer.sv | 152 +++++++++++++++
 tb/tb_ws_sram_writer.sv | 357 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ws_sram_writer.sv
// rtl/ws_sram_writer.sv - Write-S unit: clips an 8x8 IDCT block from DPRAM and writes it packed into SRAM
//
// Ports:
//   CLOCK_50_I        clock, rising edge
//   Resetn            asynchronous active-low reset
//   WS_start          start request, sampled only while idle
//   WS_done           one-cycle completion pulse
//   WS_busy           high from the cycle after acceptance through the WS_done cycle
//   RB, CB, seg       block row, block column, segment (0=Y 1=U 2=V 3=no writes); latched at start
//   RAM_read_address  DPRAM port-a address
//   RAM_read_data     DPRAM port-a q, valid the cycle after its address
//   SRAM_address      SRAM word address
//   SRAM_write_data   packed pixels {even, odd}
//   SRAM_we_n         active-low SRAM write enable
module ws_sram_writer #(
    parameter int S_BASE       = 0,
    parameter int Y_BASE       = 0,
    parameter int U_BASE       = 38400,
    parameter int V_BASE       = 57600,
    parameter int Y_ROW_WORDS  = 160,
    parameter int UV_ROW_WORDS = 80
) (
    input  logic        CLOCK_50_I,
    input  logic        Resetn,
    input  logic        WS_start,
    output logic        WS_done,
    output logic        WS_busy,
    input  logic [4:0]  RB,
    input  logic [5:0]  CB,
    input  logic [1:0]  seg,
    output logic [6:0]  RAM_read_address,
    input  logic [31:0] RAM_read_data,
    output logic [17:0] SRAM_address,
    output logic [15:0] SRAM_write_data,
    output logic        SRAM_we_n
);

    typedef enum logic [1:0] {
        S_WS_IDLE,
        S_WS_READ,
        S_WS_DRAIN,
        S_WS_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;

    // Number of the current cycle within a transfer; cycle 1 is the first after acceptance.
    logic [6:0]  r_cyc;
    logic [4:0]  r_rb;
    logic [5:0]  r_cb;
    logic [1:0]  r_seg;
    logic [4:0]  r_word;
    logic [7:0]  r_even;

    logic [7:0]  w_clip;
    logic [17:0] w_seg_base;
    logic [17:0] w_row_words;
    logic [17:0] w_row;
    logic [17:0] w_addr;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_WS_IDLE:  if (WS_start) w_next = S_WS_READ;
            S_WS_READ:  if (r_cyc == 7'd64) w_next = S_WS_DRAIN;
            S_WS_DRAIN: if (r_cyc == 7'd66) w_next = S_WS_DONE;
            S_WS_DONE:  w_next = S_WS_IDLE;
            default:    w_next = S_WS_IDLE;
        endcase
    end

    // Saturate a signed 32-bit IDCT result to an unsigned 8-bit pixel.
    always_comb begin
        w_clip = RAM_read_data[7:0];
        if (RAM_read_data[31])
            w_clip = 8'd0;
        else if (|RAM_read_data[30:8])
            w_clip = 8'hFF;
    end

    always_comb begin
        w_seg_base  = 18'(Y_BASE);
        w_row_words = 18'(Y_ROW_WORDS);
        case (r_seg)
            2'd1: begin
                w_seg_base  = 18'(U_BASE);
                w_row_words = 18'(UV_ROW_WORDS);
            end
            2'd2: begin
                w_seg_base  = 18'(V_BASE);
                w_row_words = 18'(UV_ROW_WORDS);
            end
            default: begin
                w_seg_base  = 18'(Y_BASE);
                w_row_words = 18'(Y_ROW_WORDS);
            end
        endcase
        // Each block row covers 8 pixel rows; each block column covers 4 words (8 pixels).
        w_row  = {10'd0, r_rb, 3'd0} + {15'd0, r_word[4:2]};
        w_addr = w_seg_base + w_row * w_row_words + {10'd0, r_cb, 2'd0} + {16'd0, r_word[1:0]};
    end

    always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
        if (!Resetn) begin
            r_state          <= S_WS_IDLE;
            r_cyc            <= 7'd0;
            r_rb             <= 5'd0;
            r_cb             <= 6'd0;
            r_seg            <= 2'd0;
            r_word           <= 5'd0;
            r_even           <= 8'd0;
            WS_done          <= 1'b0;
            WS_busy          <= 1'b0;
            RAM_read_address <= 7'd0;
            SRAM_address     <= 18'd0;
            SRAM_write_data  <= 16'd0;
            SRAM_we_n        <= 1'b1;
        end else begin
            r_state   <= w_next;
            WS_busy   <= (w_next != S_WS_IDLE);
            WS_done   <= (w_next == S_WS_DONE);
            SRAM_we_n <= 1'b1;
            if (r_state == S_WS_IDLE) begin
                if (WS_start) begin
                    r_rb             <= RB;
                    r_cb             <= CB;
                    r_seg            <= seg;
                    r_cyc            <= 7'd1;
                    r_word           <= 5'd0;
                    RAM_read_address <= 7'(S_BASE);
                end
            end else begin
                r_cyc <= r_cyc + 7'd1;
                if (r_cyc <= 7'd63)
                    RAM_read_address <= RAM_read_address + 7'd1;
                // Entry k arrives in cycle k+2: even cycles carry even entries, odd cycles odd ones.
                if (r_cyc >= 7'd2 && r_cyc <= 7'd65) begin
                    if (!r_cyc[0]) begin
                        r_even <= w_clip;
                    end else begin
                        SRAM_write_data <= {r_even, w_clip};
                        SRAM_address    <= w_addr;
                        SRAM_we_n       <= (r_seg == 2'd3);
                        r_word          <= r_word + 5'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ws_sram_writer.sv
// tb/tb_ws_sram_writer.sv - directed self-checking bench for ws_sram_writer
module tb_ws_sram_writer;

    logic        clk;
    logic        Resetn;
    logic        WS_start;
    logic        WS_done;
    logic        WS_busy;
    logic [4:0]  RB;
    logic [5:0]  CB;
    logic [1:0]  seg;
    logic [6:0]  RAM_read_address;
    logic [31:0] RAM_read_data;
    logic [17:0] SRAM_address;
    logic [15:0] SRAM_write_data;
    logic        SRAM_we_n;

    ws_sram_writer dut (
        .CLOCK_50_I       (clk),
        .Resetn           (Resetn),
        .WS_start         (WS_start),
        .WS_done          (WS_done),
        .WS_busy          (WS_busy),
        .RB               (RB),
        .CB               (CB),
        .seg              (seg),
        .RAM_read_address (RAM_read_address),
        .RAM_read_data    (RAM_read_data),
        .SRAM_address     (SRAM_address),
        .SRAM_write_data  (SRAM_write_data),
        .SRAM_we_n        (SRAM_we_n)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int c0 = 0;

    logic [31:0] mem [0:63];
    int          wa [$];
    logic [15:0] wd [$];
    int          wc [$];
    int          dc [$];
    int          rd [0:63];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc++;

    always @(posedge clk) RAM_read_data <= mem[RAM_read_address[5:0]];

    always @(negedge clk) begin
        int rel;
        rel = cyc - c0;
        if (SRAM_we_n === 1'b0) begin
            wa.push_back(int'(SRAM_address));
            wd.push_back(SRAM_write_data);
            wc.push_back(rel);
        end
        if (WS_done === 1'b1) dc.push_back(rel);
        if (rel >= 1 && rel <= 64) rd[rel-1] = int'(RAM_read_address);
    end

    task automatic load_ramp;
        for (int k = 0; k < 64; k++) mem[k] = 32'(k);
    endtask

    task automatic clear_log;
        wa.delete();
        wd.delete();
        wc.delete();
        dc.delete();
        for (int k = 0; k < 64; k++) rd[k] = -1;
    endtask

    // Leaves the caller #1 into cycle 1 of the new transfer.
    task automatic start_xfer(input int rb, input int cb, input int sg);
        @(posedge clk);
        #1;
        RB = 5'(rb);
        CB = 6'(cb);
        seg = 2'(sg);
        WS_start = 1'b1;
        c0 = cyc;
        clear_log();
        @(posedge clk);
        #1;
        WS_start = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        Resetn = 1'b0;
        WS_start = 1'b0;
        RB = 0;
        CB = 0;
        seg = 0;
        load_ramp();
        repeat (3) @(negedge clk);
        checks++;
        if ({WS_done, WS_busy, SRAM_we_n} !== 3'b001) begin
            errors++;
            $display("FAIL reset_ctrl got done/busy/we_n=%b required 001", {WS_done, WS_busy, SRAM_we_n});
        end
        checks++;
        if (SRAM_address !== 18'd0 || SRAM_write_data !== 16'd0 || RAM_read_address !== 7'd0) begin
            errors++;
            $display("FAIL reset_data got addr=%0d data=%h raddr=%0d required 0/0/0",
                     SRAM_address, SRAM_write_data, RAM_read_address);
        end
        @(posedge clk);
        #1;
        Resetn = 1'b1;
        wait_cycles(2);
    endtask

    task automatic test_y_corner;
        int bad;
        load_ramp();
        start_xfer(0, 0, 0);
        checks++;
        if (WS_busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_c1 got %b required 1", WS_busy);
        end
        wait_cycles(66);
        checks++;
        if (WS_busy !== 1'b1 || WS_done !== 1'b1) begin
            errors++;
            $display("FAIL c67 got busy=%b done=%b required 1 1", WS_busy, WS_done);
        end
        wait_cycles(1);
        checks++;
        if (WS_busy !== 1'b0 || WS_done !== 1'b0) begin
            errors++;
            $display("FAIL c68 got busy=%b done=%b required 0 0", WS_busy, WS_done);
        end
        wait_cycles(5);
        checks++;
        if (wa.size() != 32) begin
            errors++;
            $display("FAIL y_count got %0d required 32", wa.size());
        end else begin
            checks++;
            if (wa[0] != 0 || wa[3] != 3 || wa[4] != 160 || wa[31] != 1123) begin
                errors++;
                $display("FAIL y_addr got %0d %0d %0d %0d required 0 3 160 1123", wa[0], wa[3], wa[4], wa[31]);
            end
            checks++;
            if (wd[0] !== 16'h0001 || wd[31] !== 16'h3E3F) begin
                errors++;
                $display("FAIL y_data got %h %h required 0001 3e3f", wd[0], wd[31]);
            end
            bad = 0;
            for (int j = 0; j < 32; j++) begin
                if (wc[j] != 4 + 2 * j || wa[j] != (j >> 2) * 160 + (j & 3) ||
                    wd[j] !== {8'(2 * j), 8'(2 * j + 1)}) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("FAIL y_sweep got %0d bad words required 0", bad);
            end
        end
        checks++;
        if (dc.size() != 1 || dc[0] != 67) begin
            errors++;
            $display("FAIL y_done got %0d pulses first at %0d required 1 at 67", dc.size(), dc.size() > 0 ? dc[0] : -1);
        end
    endtask

    task automatic test_clipping;
        for (int k = 0; k < 64; k++) mem[k] = 32'd0;
        mem[0] = 32'hFFFF_FFFF;
        mem[1] = 32'd256;
        mem[2] = 32'd255;
        mem[3] = 32'h7FFF_FFFF;
        mem[4] = 32'h0000_0080;
        mem[5] = 32'h8000_0000;
        start_xfer(0, 0, 0);
        wait_cycles(72);
        checks++;
        if (wa.size() != 32) begin
            errors++;
            $display("FAIL clip_count got %0d required 32", wa.size());
        end else begin
            checks++;
            if (wd[0] !== 16'h00FF) begin
                errors++;
                $display("FAIL clip_w0 got %h required 00ff", wd[0]);
            end
            checks++;
            if (wd[1] !== 16'hFFFF) begin
                errors++;
                $display("FAIL clip_w1 got %h required ffff", wd[1]);
            end
            checks++;
            if (wd[2] !== 16'h8000) begin
                errors++;
                $display("FAIL clip_w2 got %h required 8000", wd[2]);
            end
        end
        load_ramp();
    endtask

    task automatic test_segments;
        start_xfer(29, 19, 1);
        wait_cycles(72);
        checks++;
        if (wa.size() != 32 || wa[0] != 57036 || wa[31] != 57599) begin
            errors++;
            $display("FAIL seg_u got n=%0d first=%0d last=%0d required 32 57036 57599",
                     wa.size(), wa.size() > 0 ? wa[0] : -1, wa.size() > 0 ? wa[wa.size()-1] : -1);
        end
        start_xfer(0, 0, 2);
        wait_cycles(72);
        checks++;
        if (wa.size() != 32 || wa[0] != 57600) begin
            errors++;
            $display("FAIL seg_v got n=%0d first=%0d required 32 57600", wa.size(), wa.size() > 0 ? wa[0] : -1);
        end
        start_xfer(29, 39, 0);
        wait_cycles(72);
        checks++;
        if (wa.size() != 32 || wa[31] != 38399) begin
            errors++;
            $display("FAIL seg_y_last got n=%0d last=%0d required 32 38399",
                     wa.size(), wa.size() > 0 ? wa[wa.size()-1] : -1);
        end
    endtask

    task automatic test_handshake;
        start_xfer(0, 0, 0);
        wait_cycles(9);
        RB = 5'd5;
        CB = 6'd7;
        seg = 2'd1;
        wait_cycles(10);
        WS_start = 1'b1;
        wait_cycles(1);
        WS_start = 1'b0;
        RB = 0;
        CB = 0;
        seg = 0;
        wait_cycles(60);
        checks++;
        if (wa.size() != 32 || wa[0] != 0 || wa[31] != 1123) begin
            errors++;
            $display("FAIL ignore_start got n=%0d first=%0d last=%0d required 32 0 1123",
                     wa.size(), wa.size() > 0 ? wa[0] : -1, wa.size() > 0 ? wa[wa.size()-1] : -1);
        end
        checks++;
        if (dc.size() != 1 || dc[0] != 67) begin
            errors++;
            $display("FAIL ignore_done got %0d pulses required 1 at 67", dc.size());
        end
        @(posedge clk);
        #1;
        WS_start = 1'b1;
        c0 = cyc;
        clear_log();
        wait_cycles(100);
        WS_start = 1'b0;
        wait_cycles(45);
        checks++;
        if (wa.size() != 64 || wc[32] != 72) begin
            errors++;
            $display("FAIL held_start got n=%0d second_first_cycle=%0d required 64 72",
                     wa.size(), wa.size() > 32 ? wc[32] : -1);
        end
        checks++;
        if (dc.size() != 2 || dc[1] != 135) begin
            errors++;
            $display("FAIL held_done got %0d pulses required 2 at 67 and 135", dc.size());
        end
    endtask

    task automatic test_reset_mid;
        int n;
        start_xfer(0, 0, 0);
        wait_cycles(29);
        Resetn = 1'b0;
        #1;
        checks++;
        if ({WS_done, WS_busy, SRAM_we_n} !== 3'b001 || SRAM_address !== 18'd0 ||
            SRAM_write_data !== 16'd0 || RAM_read_address !== 7'd0) begin
            errors++;
            $display("FAIL mid_reset got done=%b busy=%b we_n=%b addr=%0d data=%h raddr=%0d required 0 0 1 0 0000 0",
                     WS_done, WS_busy, SRAM_we_n, SRAM_address, SRAM_write_data, RAM_read_address);
        end
        n = wa.size();
        checks++;
        if (n != 13) begin
            errors++;
            $display("FAIL pre_reset_writes got %0d required 13", n);
        end
        wait_cycles(80);
        checks++;
        if (wa.size() != n || dc.size() != 0) begin
            errors++;
            $display("FAIL post_reset_quiet got writes=%0d done=%0d required %0d 0", wa.size(), dc.size(), n);
        end
        Resetn = 1'b1;
        wait_cycles(2);
        start_xfer(0, 0, 0);
        wait_cycles(72);
        checks++;
        if (wa.size() != 32 || wa[31] != 1123 || wd[31] !== 16'h3E3F || wd[0] !== 16'h0001) begin
            errors++;
            $display("FAIL after_reset got n=%0d required 32 words ending 1123/3e3f", wa.size());
        end
    endtask

    task automatic test_seg3;
        int bad;
        start_xfer(3, 4, 3);
        wait_cycles(72);
        checks++;
        if (wa.size() != 0) begin
            errors++;
            $display("FAIL seg3_writes got %0d required 0", wa.size());
        end
        bad = 0;
        for (int k = 0; k < 64; k++) if (rd[k] != k) bad++;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL seg3_reads got %0d wrong addresses required 0", bad);
        end
        checks++;
        if (dc.size() != 1 || dc[0] != 67) begin
            errors++;
            $display("FAIL seg3_done got %0d pulses required 1 at 67", dc.size());
        end
    endtask

    initial begin
        clear_log();
        test_reset();
        test_y_corner();
        test_clipping();
        test_segments();
        test_handshake();
        test_reset_mid();
        test_seg3();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
